rib_master_arbiter: RTL and testbench
=====================================

Name: rib_master_arbiter

Overview:
- Registered arbiter that shares the RIB slave fabric between its four masters:
  - m0: core ex load/store
  - m1: core pc fetch
  - m2: jtag debug
  - m3: uart_debug download
- Produces a one-hot grant, the grant index and a hold flag for the core.
- Supports fixed-priority or round-robin selection, multi-cycle bus locking and starvation breaking.
- Sits between the master request lines and the rib mux, replacing its combinational priority chain.

Parameters:
- STARVE_MAX, 15: cycles a requesting, ungranted master waits before it is force-granted.
- CNT_W, 4: width of each starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req_i  input  4  per-master bus request; bit n is master n
- lock_i  input  4  per-master lock; the owner keeps the bus while req_i[n] and lock_i[n] are both high
- prio_mode_i  input  1  0 = fixed priority, 1 = round-robin; sampled every cycle
- gnt_o  output  4  registered one-hot grant; all zero when idle
- gnt_idx_o  output  2  index of the current owner; holds its last value when idle
- gnt_valid_o  output  1  high when gnt_o is non-zero
- hold_o  output  1  core stall request: (req_i[0]&~gnt_o[0]) | (req_i[1]&~gnt_o[1]); combinational from the registered grant
- starve_o  output  4  bit n high while master n's counter equals STARVE_MAX

Behaviour:
- Reset (synchronous, rst=1 at the clk edge):
  - gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, starve_o=0, hold_o=0.
  - State goes to IDLE, the round-robin pointer to 0 and all counters to 0.
  - Reset mid-lock drops the grant at that edge with no completion.
- States: IDLE (no owner) and OWNED (gnt_o one-hot).
- Latency: a request raised in cycle t is granted at the edge ending cycle t, visible in t+1, when it wins.
- Arbitration runs at every edge except when the owner holds a lock:
  - Arbitration candidates: all n with req_i[n]=1.
  - Fixed mode order: m3 > m2 > m0 > m1.
  - Round-robin mode: search starts at (last owner + 1) mod 4, ascending with wrap. The pointer updates only on a new grant to a different master.
  - Starvation override: any master with counter==STARVE_MAX beats mode order. If several are starved, the lowest index wins.
- OWNED, lock held (req_i[own]=1, lock_i[own]=1): keep the grant and skip arbitration, unless another master is starved. In that case the lock is broken and the starved master is granted next edge.
- OWNED, owner requesting without lock: rearbitrate; the owner competes normally and may be re-granted.
- OWNED, owner drops req_i:
  - Rearbitrate at the same edge; the handoff to a new owner takes no idle cycle.
  - If no requests remain, go to IDLE with gnt_o=0.
- IDLE with req_i=0: stay in IDLE.
- Starvation counter n:
  - If req_i[n]=1 and gnt_o[n]=0: increment, saturating at STARVE_MAX.
  - If gnt_o[n]=1 or req_i[n]=0: clear to 0.
- Simultaneous owner release and new requests: the new requests are arbitrated in the same cycle.
- A lock asserted on a cycle the master is not the owner has no effect.

Optional Feature:
- Macro: RIB_ARB_STARVE_EN
- Defined: starvation counters, the override and starve_o behave as above.
- Undefined:
  - Counters are removed and starve_o is tied to 0.
  - A lock is held indefinitely while req_i and lock_i stay high.
  - Arbitration uses mode order only.

Test Plan:
- Fixed mode, req_i=4'b1111 from IDLE → next cycle gnt_o=4'b1000, gnt_idx_o=3, hold_o=1. Drop req_i[3] → gnt_o=4'b0100 one cycle later.
- Round-robin, req_i=4'b1111 held with lock_i=0 for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. hold_o=1 exactly on cycles m0 or m1 is not granted.
- m2 locks (req=1, lock=1) while m0 requests continuously, STARVE_MAX=15 → starve_o[0] rises after 15 waiting cycles. gnt_o=4'b0001 on the next edge. With the macro undefined, m2 keeps the bus and starve_o stays 0.
- Owner m0 drops its request in the same cycle m1 raises one → gnt_o goes 0001→0010 with no idle cycle, gnt_valid_o stays 1.
- rst=1 asserted during an m3 lock → next cycle gnt_o=0, gnt_valid_o=0, starve_o=0. After release, req_i=4'b0010 → gnt_o=4'b0010.
- All requests drop → IDLE: gnt_o=0, gnt_valid_o=0, gnt_idx_o keeps its last value, hold_o=0.

Source files
------------

// File: rtl/rib_master_arbiter.sv
// -----------------------------------------------------------------------------
// rib_master_arbiter
//
// Registered arbiter that shares the RIB slave fabric between four masters:
//   m0 core ex load/store, m1 core pc fetch, m2 jtag debug, m3 uart download.
// Selection is fixed priority (m3 > m2 > m0 > m1) or round-robin. An owner
// holds the bus while it keeps both its request and its lock high. Starvation
// counters force-grant a master that has waited STARVE_MAX cycles, breaking a
// lock if necessary.
//
// Optional feature macro: RIB_ARB_STARVE_EN
//   defined   : starvation counters, override and starve_o are present.
//   undefined : no counters, starve_o tied to 0, locks are held indefinitely.
//
// Parameters:
//   STARVE_MAX  cycles a requesting, ungranted master waits before force-grant
//   CNT_W       width of each starvation counter (2**CNT_W > STARVE_MAX)
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   req_i[3:0]   per-master bus request
//   lock_i[3:0]  per-master lock; effective only for the current owner
//   prio_mode_i  0 = fixed priority, 1 = round-robin
//   gnt_o[3:0]   registered one-hot grant, zero when idle
//   gnt_idx_o    index of the current owner, holds last value when idle
//   gnt_valid_o  high when gnt_o is non-zero
//   hold_o       core stall: m0 or m1 requesting but not granted
//   starve_o     bit n high while master n's counter equals STARVE_MAX
// -----------------------------------------------------------------------------
module rib_master_arbiter #(
   parameter int STARVE_MAX = 15,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_i,
   input  logic [3:0] lock_i,
   input  logic       prio_mode_i,
   output logic [3:0] gnt_o,
   output logic [1:0] gnt_idx_o,
   output logic       gnt_valid_o,
   output logic       hold_o,
   output logic [3:0] starve_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_e;

   // Reject a counter too narrow to ever reach STARVE_MAX.
   if (CNT_W < 1 || (1 << CNT_W) <= STARVE_MAX) begin : g_bad_cfg
      $error("rib_master_arbiter: CNT_W too small for STARVE_MAX");
   end

   state_e     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] idx_q, idx_d;
   logic [1:0] rr_ptr_q, rr_ptr_d;

   logic [3:0] starved;       // counters at STARVE_MAX
   logic [3:0] starve_req;    // starved masters still requesting
   logic       starve_hit;
   logic [1:0] starve_idx;
   logic [1:0] fix_idx;
   logic [1:0] rr_idx;
   logic       lock_hold;

`ifdef RIB_ARB_STARVE_EN
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         starved[n] = (cnt_q[n] == CNT_W'(STARVE_MAX));
         // Count while waiting, saturate at STARVE_MAX, clear once served or idle.
         if (req_i[n] && !gnt_q[n]) begin
            cnt_d[n] = starved[n] ? cnt_q[n] : cnt_q[n] + CNT_W'(1);
         end else begin
            cnt_d[n] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < 4; n++) cnt_q[n] <= '0;
      end else begin
         for (int n = 0; n < 4; n++) cnt_q[n] <= cnt_d[n];
      end
   end
`else
   assign starved = 4'b0000;
`endif

   assign starve_req = starved & req_i;
   assign starve_hit = |starve_req;

   // Candidate selection for each policy, all evaluated in parallel.
   always_comb begin
      // Starvation override: lowest starved index wins.
      starve_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (starve_req[i]) starve_idx = 2'(i);
      end

      // Fixed order m3 > m2 > m0 > m1.
      if (req_i[3])      fix_idx = 2'd3;
      else if (req_i[2]) fix_idx = 2'd2;
      else if (req_i[0]) fix_idx = 2'd0;
      else               fix_idx = 2'd1;

      // Round-robin: offset 1 is searched first, the last owner (offset 0)
      // last. Iterating the offsets downward lets the nearest one win.
      rr_idx = rr_ptr_q;
      for (int k = 4; k >= 1; k--) begin
         if (req_i[rr_ptr_q + 2'(k)]) rr_idx = rr_ptr_q + 2'(k);
      end
   end

   assign lock_hold = (state_q == OWNED) && req_i[idx_q] && lock_i[idx_q];

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      idx_d    = idx_q;
      rr_ptr_d = rr_ptr_q;

      if (lock_hold && !starve_hit) begin
         // Locked owner keeps the bus; no arbitration this edge.
      end else if (req_i == 4'b0000) begin
         state_d = IDLE;
         gnt_d   = 4'b0000;
      end else begin
         state_d = OWNED;
         if (starve_hit)       idx_d = starve_idx;
         else if (prio_mode_i) idx_d = rr_idx;
         else                  idx_d = fix_idx;
         gnt_d = 4'b0001 << idx_d;
         if (idx_d != rr_ptr_q) rr_ptr_d = idx_d;
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= 4'b0000;
         idx_q    <= 2'd0;
         rr_ptr_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         idx_q    <= idx_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_idx_o   = idx_q;
   assign gnt_valid_o = (state_q == OWNED);
   assign hold_o      = (req_i[0] & ~gnt_q[0]) | (req_i[1] & ~gnt_q[1]);
   assign starve_o    = starved;

endmodule

// File: tb/tb_rib_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rib_master_arbiter
//
// Directed scoreboard bench for rib_master_arbiter. The stimulus process
// drives one cycle of inputs just after each rising edge and pushes the
// hand-computed outputs expected for that cycle; a monitor pops and compares
// on the falling edge. Expectations follow RIB_ARB_STARVE_EN.
// -----------------------------------------------------------------------------
module tb_rib_master_arbiter;

   typedef struct {
      int         cyc;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       valid;
      logic       hold;
      logic [3:0] starve;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] req_i;
   logic [3:0] lock_i;
   logic       prio_mode_i;
   logic [3:0] gnt_o;
   logic [1:0] gnt_idx_o;
   logic       gnt_valid_o;
   logic       hold_o;
   logic [3:0] starve_o;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc_no   = 0;

`ifdef RIB_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   rib_master_arbiter #(.STARVE_MAX(15), .CNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_i),
      .lock_i      (lock_i),
      .prio_mode_i (prio_mode_i),
      .gnt_o       (gnt_o),
      .gnt_idx_o   (gnt_idx_o),
      .gnt_valid_o (gnt_valid_o),
      .hold_o      (hold_o),
      .starve_o    (starve_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int cyc,
                        input logic [3:0] act, input logic [3:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, req);
      end
   endtask

   // One cycle of stimulus plus the outputs expected while it is applied.
   task automatic cyc(input logic r, input logic [3:0] req, input logic [3:0] lck,
                      input logic md, input logic [3:0] eg, input logic [1:0] ei,
                      input logic [3:0] es);
      exp_t e;
      @(posedge clk);
      #1;
      rst         = r;
      req_i       = req;
      lock_i      = lck;
      prio_mode_i = md;
      e.cyc    = cyc_no;
      e.gnt    = eg;
      e.idx    = ei;
      e.valid  = |eg;
      e.hold   = (req[0] & ~eg[0]) | (req[1] & ~eg[1]);
      e.starve = es;
      exp_q.push_back(e);
      cyc_no++;
   endtask

   // Monitor: compares the visible outputs mid-cycle against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("gnt",    e.cyc, gnt_o,                e.gnt);
            check("idx",    e.cyc, {2'b00, gnt_idx_o},   {2'b00, e.idx});
            check("valid",  e.cyc, {3'b000, gnt_valid_o}, {3'b000, e.valid});
            check("hold",   e.cyc, {3'b000, hold_o},     {3'b000, e.hold});
            check("starve", e.cyc, starve_o,             e.starve);
         end
      end
   end

   initial begin
      int wait_cnt;
      rst         = 1'b1;
      req_i       = 4'b0000;
      lock_i      = 4'b0000;
      prio_mode_i = 1'b0;
      repeat (3) @(posedge clk);

      // Reset state, then fixed priority from idle.
      cyc(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 4'b0000);
      cyc(0, 4'b1111, 4'b0000, 0, 4'b0000, 2'd0, 4'b0000);
      cyc(0, 4'b1111, 4'b0000, 0, 4'b1000, 2'd3, 4'b0000);
      cyc(0, 4'b0111, 4'b0000, 0, 4'b1000, 2'd3, 4'b0000);
      cyc(0, 4'b0111, 4'b0000, 0, 4'b0100, 2'd2, 4'b0000);
      // Hand the bus back to m3 so round-robin starts searching at m0.
      cyc(0, 4'b1000, 4'b0000, 0, 4'b0100, 2'd2, 4'b0000);
      cyc(0, 4'b1111, 4'b0000, 1, 4'b1000, 2'd3, 4'b0000);
      // Round-robin with all requesting: 0,1,2,3,0,1,2,3.
      for (int i = 0; i < 8; i++) begin
         cyc(0, 4'b1111, 4'b0000, 1, 4'b0001 << (i % 4), 2'(i % 4), 4'b0000);
      end
      // m0 releases as m1 requests: direct handoff, then idle.
      cyc(0, 4'b0010, 4'b0000, 0, 4'b0001, 2'd0, 4'b0000);
      cyc(0, 4'b0000, 4'b0000, 0, 4'b0010, 2'd1, 4'b0000);
      cyc(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd1, 4'b0000);
      // m2 locks while m0 waits; m1 lock bit is ignored (not owner).
      cyc(0, 4'b0101, 4'b0110, 0, 4'b0000, 2'd1, 4'b0000);
      for (int i = 0; i < 14; i++) begin
         cyc(0, 4'b0101, 4'b0100, 0, 4'b0100, 2'd2, 4'b0000);
      end
      cyc(0, 4'b0101, 4'b0100, 0, 4'b0100, 2'd2, STARVE ? 4'b0001 : 4'b0000);
      cyc(0, 4'b0000, 4'b0000, 0, STARVE ? 4'b0001 : 4'b0100,
          STARVE ? 2'd0 : 2'd2, STARVE ? 4'b0001 : 4'b0000);
      // m3 locks, then reset drops the grant mid-lock.
      cyc(0, 4'b1000, 4'b1000, 0, 4'b0000, STARVE ? 2'd0 : 2'd2, 4'b0000);
      cyc(0, 4'b1000, 4'b1000, 0, 4'b1000, 2'd3, 4'b0000);
      cyc(1, 4'b1000, 4'b1000, 0, 4'b1000, 2'd3, 4'b0000);
      cyc(0, 4'b0010, 4'b0000, 0, 4'b0000, 2'd0, 4'b0000);
      cyc(0, 4'b0000, 4'b0000, 0, 4'b0010, 2'd1, 4'b0000);
      cyc(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd1, 4'b0000);

      // Let the monitor drain, bounded.
      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
